stmpe610_spi_responder: RTL and testbench
=========================================

# stmpe610_spi_responder

SPI mode-0 target that emulates the STMPE610 touch-controller register interface, the far end of the SPI link the `top` design drives on STMPE610_CS_N / MOSI / SCLK. It oversamples the SPI pins on SYSCLK, decodes the STMPE610 address/read-write framing, and serves an internal byte register file. Register writes are also reported on a strobe port. It serves as the in-system touch-controller stand-in for simulation and board loopback of the SPI master.

## Interface
- ADDR_W, 4: register address width; the map holds 2**ADDR_W bytes.
- CHIP_ID, 16'h0811: value returned at addresses 0 (high byte) and 1 (low byte).
- SYSCLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- SCLK  in  1  SPI clock from the master, asynchronous to SYSCLK, idle low.
- CS_N  in  1  active-low chip select, asynchronous.
- MOSI  in  1  master-out data, asynchronous.
- MISO  out  1  target-out data.
- MISO_OE  out  1  high while selected; the pad tristates MISO when low.
- BUSY  out  1  high while a transaction is in progress (synchronized CS_N low).
- WR_STB  out  1  one-cycle pulse per accepted register write.
- WR_ADDR  out  ADDR_W  address of the accepted write, valid with WR_STB.
- WR_DATA  out  8  data of the accepted write, valid with WR_STB.

## Operation
- SCLK, CS_N and MOSI each pass through a 2-flop synchronizer.
- A third flop on SCLK and CS_N provides edge detection: rise = cur & ~prev, fall = ~cur & prev.
- Protocol is MSB first.
  - Byte 0 is the address byte: bit7 = 1 for a read, 0 for a write; bits[ADDR_W-1:0] give the start address; remaining bits are ignored.
  - Subsequent bytes are data. The address auto-increments after each data byte and wraps modulo 2**ADDR_W.
- MOSI is sampled on each synchronized SCLK rise into an 8-bit shift register and a 3-bit bit counter.
- FSM states:
  - IDLE: CS_N fall -> ADDR.
  - ADDR: 8th rise -> RDATA if bit7 = 1, else WDATA.
  - WDATA: each 8th rise completes a byte.
    - If the address is not 0 or 1, write the register and pulse WR_STB/WR_ADDR/WR_DATA on the next cycle.
    - Addresses 0 and 1 are read-only: the write is dropped, with no WR_STB.
    - Increment the address in both cases.
  - RDATA: shift the next bit out of the read shift register on each SCLK fall. The next byte reloads after every 8 bits and the address increments.
  - Any state: CS_N rise -> IDLE. The bit counter clears and any partial byte is discarded, with no write and no strobe.
- MISO drive:
  - On the SCLK fall that follows the 8th address rise, load mem[addr] and drive its bit7. Each later fall drives the next bit.
  - MISO is 0 in IDLE, in ADDR and in WDATA.
- MISO_OE = BUSY = synchronized CS_N low and FSM not IDLE.
- Register file resets to 0x00, except addresses 0 and 1, which always read CHIP_ID[15:8] and CHIP_ID[7:0].
- Reset mid-transaction:
  - All outputs go to their reset values immediately (asynchronous).
  - The FSM enters IDLE and ignores the current frame until CS_N has been seen high and then falls.

## Timing
- Reset values: MISO 0, MISO_OE 0, BUSY 0, WR_STB 0, WR_ADDR 0, WR_DATA 0.
- SCLK high and low times must each be ≥ 4 SYSCLK periods. CS_N setup before the first SCLK rise and hold after the last fall must each be ≥ 4 SYSCLK periods.
- Pin edge to internal edge pulse: 3 SYSCLK.
- MISO changes 4 SYSCLK after the SCLK pin fall, which leaves ≥ 0 SYSCLK of setup before the master's next rise at the minimum SCLK rate.
- WR_STB asserts 4 SYSCLK after the 8th data-bit SCLK pin rise and lasts exactly 1 cycle. Strobes for consecutive bytes are ≥ 16 SYSCLK apart.
- BUSY rises 3 SYSCLK after the CS_N pin fall and falls 3 SYSCLK after the CS_N pin rise.
- A CS_N rise and an SCLK edge detected in the same cycle: the CS_N rise wins and the edge is ignored.

## Test plan
- Use an SCLK period of 10 SYSCLK for all scenarios.
- Write 0x03, 0xA5 -> exactly one WR_STB with WR_ADDR=3 and WR_DATA=0xA5. Then read 0x83 plus one dummy byte -> MISO returns 0xA5 MSB first and MISO_OE is high throughout.
- Chip ID: read 0x80 plus two dummy bytes -> MISO returns 0x08 then 0x11. Write 0x00, 0x55 -> no WR_STB and the ID still reads 0x08.
- Burst wrap (ADDR_W=4): write 0x0E, 0x11, 0x22, 0x33 -> WR_STB at addr 0xE (0x11) and 0xF (0x22) only, since the third byte lands on read-only addr 0. Then read 0x8E plus two dummy bytes -> 0x11, 0x22.
- Abort: raise CS_N after the address byte 0x05 and 5 data bits -> no WR_STB, BUSY drops after 3 cycles. A following write 0x05, 0x3C -> WR_STB with addr 5, data 0x3C.
- Reset mid-frame: assert RST during WDATA bit 3 -> all outputs are 0 within the same cycle and no strobe occurs. After release, a full new frame writes normally and register 5 reads 0x00.

Source files
------------

// File: rtl/stmpe610_spi_responder.sv
`default_nettype none
// ============================================================================
// stmpe610_spi_responder : SPI mode-0 target emulating the STMPE610 register map
// Rev 1.0
// ============================================================================
module stmpe610_spi_responder #(
    parameter int          ADDR_W  = 4,
    parameter logic [15:0] CHIP_ID = 16'h0811
) (
    input  logic              SYSCLK,
    input  logic              RST,
    input  logic              SCLK,
    input  logic              CS_N,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    output logic              BUSY,
    output logic              WR_STB,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [7:0]        WR_DATA
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_WDATA = 2'd2;
    localparam logic [1:0] S_RDATA = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        sclk_sync_q, sclk_sync_d;
    logic [2:0]        cs_sync_q, cs_sync_d;
    logic [1:0]        mosi_sync_q, mosi_sync_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]        pend_data_q, pend_data_d;
    logic              wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              miso_q, miso_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];

    logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic              busy;
    logic              addr_ro;
    logic [7:0]        byte_in;
    logic [7:0]        rd_byte;

    // Stage [0] and [1] synchronize; stage [2] is the previous value for edge detection.
    assign sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    assign cs_sync_d   = {cs_sync_q[1:0], CS_N};
    assign mosi_sync_d = {mosi_sync_q[0], MOSI};

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];

    assign byte_in = {rx_q[6:0], mosi_sync_q[1]};
    assign addr_ro = (addr_q == ADDR_W'(0)) || (addr_q == ADDR_W'(1));

    always_comb begin
        rd_byte = mem_q[addr_q];
        if (addr_q == ADDR_W'(0)) begin
            rd_byte = CHIP_ID[15:8];
        end else if (addr_q == ADDR_W'(1)) begin
            rd_byte = CHIP_ID[7:0];
        end
    end

    // CS_N synchronizer resets low so a frame already in progress at reset
    // release never looks like a fresh CS_N fall.
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            miso_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            miso_q      <= miso_d;
            mem_q       <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (cs_fall) state_d = S_ADDR;
                S_ADDR: if (sclk_rise && bit_cnt_q == 3'd7) state_d = rx_q[6] ? S_RDATA : S_WDATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy   = ~cs_sync_q[2] && (state_q != S_IDLE);
        miso_d = (state_q == S_RDATA) ? tx_q[7] : 1'b0;
    end

    // A CS_N rise takes priority over any SCLK edge seen in the same cycle.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        wr_stb_d    = pend_q;
        wr_addr_d   = pend_q ? pend_addr_q : wr_addr_q;
        wr_data_d   = pend_q ? pend_data_q : wr_data_q;
        mem_d       = mem_q;
        if (pend_q) begin
            mem_d[pend_addr_q] = pend_data_q;
        end

        if (cs_rise || state_q == S_IDLE) begin
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            rx_d      = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                if (state_q == S_ADDR) begin
                    addr_d = byte_in[ADDR_W-1:0];
                    tx_d   = '0;
                end else if (state_q == S_WDATA) begin
                    if (!addr_ro) begin
                        pend_d      = 1'b1;
                        pend_addr_d = addr_q;
                        pend_data_d = byte_in;
                    end
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
        end else if (sclk_fall && state_q == S_RDATA) begin
            if (bit_cnt_q == 3'd0) begin
                tx_d   = rd_byte;
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end
    end

    assign MISO    = miso_q;
    assign MISO_OE = busy;
    assign BUSY    = busy;
    assign WR_STB  = wr_stb_q;
    assign WR_ADDR = wr_addr_q;
    assign WR_DATA = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_stmpe610_spi_responder.sv
`default_nettype none
// ============================================================================
// tb_stmpe610_spi_responder : SPI-master bench with a register-map reference model
// Rev 1.0
// ============================================================================
module tb_stmpe610_spi_responder;

    logic       SYSCLK = 1'b0;
    logic       RST;
    logic       SCLK;
    logic       CS_N;
    logic       MOSI;
    logic       MISO;
    logic       MISO_OE;
    logic       BUSY;
    logic       WR_STB;
    logic [3:0] WR_ADDR;
    logic [7:0] WR_DATA;

    stmpe610_spi_responder #(.ADDR_W(4), .CHIP_ID(16'h0811)) dut (
        .SYSCLK  (SYSCLK),
        .RST     (RST),
        .SCLK    (SCLK),
        .CS_N    (CS_N),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MISO_OE (MISO_OE),
        .BUSY    (BUSY),
        .WR_STB  (WR_STB),
        .WR_ADDR (WR_ADDR),
        .WR_DATA (WR_DATA)
    );

    always #5 SYSCLK = ~SYSCLK;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  model_mem [16];
    logic [7:0]  tx_bytes [$];
    logic [7:0]  rx_bytes [$];
    logic [11:0] stb_seen [$];
    logic [11:0] stb_exp  [$];
    int          oe_low;

    always @(negedge SYSCLK) begin
        if (WR_STB === 1'b1) stb_seen.push_back({WR_ADDR, WR_DATA});
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    function automatic logic [7:0] model_read(input int a);
        if (a == 0) return 8'h08;
        if (a == 1) return 8'h11;
        return model_mem[a];
    endfunction

    // Drives one CS_N frame of nbits bits (SCLK period 10 SYSCLK); optional reset at bit rst_at.
    task automatic spi_frame(input int nbits, input int rst_at);
        logic [7:0] b;
        logic [7:0] cur;
        rx_bytes.delete();
        oe_low = 0;
        cur    = '0;
        CS_N   = 1'b0;
        clk_n(2);
        total++;
        if (BUSY !== 1'b0) begin bad++; $display("FAIL busy_rise_early: got %b want 0", BUSY); end
        clk_n(1);
        total++;
        if (BUSY !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b want 1", BUSY); end
        clk_n(2);
        for (int i = 0; i < nbits; i++) begin
            b    = tx_bytes[i / 8];
            MOSI = b[7 - (i % 8)];
            if (i == rst_at) begin
                #3;
                total++;
                if (BUSY !== 1'b1) begin bad++; $display("FAIL busy_before_rst: got %b want 1", BUSY); end
                RST = 1'b1;
                #1;
                total++;
                if ({MISO, MISO_OE, BUSY, WR_STB, WR_ADDR, WR_DATA} !== 16'h0) begin
                    bad++;
                    $display("FAIL async_reset_outputs: got miso=%b oe=%b busy=%b stb=%b addr=%h data=%h want all 0",
                             MISO, MISO_OE, BUSY, WR_STB, WR_ADDR, WR_DATA);
                end
                for (int k = 0; k < 16; k++) model_mem[k] = 8'h00;
                clk_n(3);
                RST = 1'b0;
            end
            clk_n(5);
            SCLK = 1'b1;
            cur  = {cur[6:0], MISO};
            if (MISO_OE !== 1'b1) oe_low++;
            clk_n(5);
            SCLK = 1'b0;
            if (i % 8 == 7) rx_bytes.push_back(cur);
        end
        clk_n(5);
        CS_N = 1'b1;
        MOSI = 1'b0;
        if (rst_at < 0) begin
            clk_n(2);
            total++;
            if (BUSY !== 1'b1) begin bad++; $display("FAIL busy_fall_early: got %b want 1", BUSY); end
            clk_n(1);
            total++;
            if (BUSY !== 1'b0) begin bad++; $display("FAIL busy_fall: got %b want 0", BUSY); end
            clk_n(6);
        end else begin
            clk_n(9);
        end
    endtask

    task automatic check_strobes(input string name);
        total++;
        if (stb_seen.size() != stb_exp.size()) begin
            bad++;
            $display("FAIL %s strobe_count: got %0d want %0d", name, stb_seen.size(), stb_exp.size());
        end else begin
            for (int i = 0; i < stb_exp.size(); i++) begin
                total++;
                if (stb_seen[i] !== stb_exp[i]) begin
                    bad++;
                    $display("FAIL %s strobe%0d: got addr=%h data=%h want addr=%h data=%h", name, i,
                             stb_seen[i][11:8], stb_seen[i][7:0], stb_exp[i][11:8], stb_exp[i][7:0]);
                end
            end
        end
    endtask

    // Complete frame of header + ndata bytes, predicted from the register-map rules.
    task automatic run_frame(input string name, input int ndata);
        logic [7:0] h;
        logic [7:0] d;
        logic [7:0] exp_rd [$];
        int         a;
        h = tx_bytes[0];
        a = int'(h[3:0]);
        stb_exp.delete();
        stb_seen.delete();
        for (int i = 1; i <= ndata; i++) begin
            d = tx_bytes[i];
            if (h[7]) begin
                exp_rd.push_back(model_read(a));
            end else if (a > 1) begin
                model_mem[a] = d;
                stb_exp.push_back({a[3:0], d});
            end
            a = (a + 1) % 16;
        end
        spi_frame(8 * (ndata + 1), -1);
        check_strobes(name);
        if (h[7]) begin
            for (int i = 0; i < ndata; i++) begin
                total++;
                if (rx_bytes[i + 1] !== exp_rd[i]) begin
                    bad++;
                    $display("FAIL %s read%0d: got %h want %h", name, i, rx_bytes[i + 1], exp_rd[i]);
                end
            end
            total++;
            if (oe_low != 0) begin bad++; $display("FAIL %s miso_oe: got %0d low samples want 0", name, oe_low); end
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; SCLK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
        for (int k = 0; k < 16; k++) model_mem[k] = 8'h00;
        clk_n(4);
        total++;
        if ({MISO, MISO_OE, BUSY, WR_STB, WR_ADDR, WR_DATA} !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got miso=%b oe=%b busy=%b stb=%b addr=%h data=%h want all 0",
                     MISO, MISO_OE, BUSY, WR_STB, WR_ADDR, WR_DATA);
        end
        RST = 1'b0;
        clk_n(6);
        total++;
        if (BUSY !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_write_read;
        tx_bytes = '{8'h03, 8'hA5};         run_frame("write_03", 1);
        tx_bytes = '{8'h83, 8'h00};         run_frame("read_03", 1);
    endtask

    task automatic test_chip_id;
        tx_bytes = '{8'h80, 8'h00, 8'h00};  run_frame("chip_id", 2);
        tx_bytes = '{8'h00, 8'h55};         run_frame("write_ro", 1);
        tx_bytes = '{8'h80, 8'h00};         run_frame("chip_id_again", 1);
    endtask

    task automatic test_burst_wrap;
        tx_bytes = '{8'h0E, 8'h11, 8'h22, 8'h33}; run_frame("burst_wrap", 3);
        tx_bytes = '{8'h8E, 8'h00, 8'h00};        run_frame("burst_read", 2);
    endtask

    task automatic test_abort;
        tx_bytes = '{8'h05, 8'hFF};
        stb_exp.delete();
        stb_seen.delete();
        spi_frame(13, -1);
        check_strobes("abort");
        tx_bytes = '{8'h05, 8'h3C};         run_frame("after_abort", 1);
        tx_bytes = '{8'h85, 8'h00};         run_frame("read_05", 1);
    endtask

    task automatic test_reset_midframe;
        tx_bytes = '{8'h07, 8'h9A};
        stb_exp.delete();
        stb_seen.delete();
        spi_frame(16, 11);
        check_strobes("reset_midframe");
        tx_bytes = '{8'h07, 8'h5E};         run_frame("post_reset_write", 1);
        tx_bytes = '{8'h85, 8'h00};         run_frame("post_reset_read5", 1);
        tx_bytes = '{8'h87, 8'h00};         run_frame("post_reset_read7", 1);
    endtask

    task automatic test_random;
        int n;
        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(1, 4);
            tx_bytes.delete();
            tx_bytes.push_back(8'($urandom));
            for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
            run_frame("random", n);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_chip_id();
        test_burst_wrap();
        test_abort();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
`default_nettype wire
